seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
// PURPOSE
//   Time-multiplexed scan controller for a NUM_DIGITS common-anode/cathode hex display.
//   Shares one external seven_seg_hex decoder across all digits: drives the nibble for the
//   current digit, registers the returned segments and walks digit enables with a blanking gap.
//   Accepts new display values by valid/ready and applies them only at frame boundaries (no tearing).
// PARAMETERS
//   NUM_DIGITS      4     digits scanned, digit 0 = least-significant nibble (>=2)
//   DIGIT_TICKS     1000  clk cycles a digit is lit per slot (>=1)
//   BLANK_TICKS     16    clk cycles all digits dark before each digit (>=1), anti-ghosting
//   SEG_ACTIVE_LOW  0     1: invert seg_out (segment on = 0)
//   AN_ACTIVE_LOW   1     1: digit enable on = 0
// PORTS
//   clk          in   1              system clock, all logic rising-edge
//   rst_n        in   1              asynchronous active-low reset
//   value_in     in   4*NUM_DIGITS   packed hex value, nibble i -> digit i
//   value_valid  in   1              value_in offered
//   value_ready  out  1              pending slot free; transfer = valid & ready
//   lz_suppress  in   1              1: blank leading zero digits (sampled at frame boundary)
//   dec_nibble   out  4              nibble to shared decoder din (combinational from state)
//   dec_seg      in   7              decoder dout, active-high, bit0=a .. bit6=g
//   seg_out      out  7              segment drive, registered
//   an_out       out  NUM_DIGITS     digit enables, registered, at most one active
//   frame_done   out  1              1-cycle pulse at each frame boundary
// BEHAVIOUR
//   Reset (async, rst_n=0): state=BLANK, idx=0, tick=0, active value=0, pending empty,
//     lz latch=0, seg_out=all off, an_out=all inactive, value_ready=1, frame_done=0. Pending
//     value discarded; reset mid-scan darkens outputs immediately.
//   FSM per digit slot: BLANK (BLANK_TICKS cycles) -> SHOW (DIGIT_TICKS cycles) -> BLANK, idx+1.
//     tick counts 0..N-1 in each state, clears on transition.
//   Frame boundary = last SHOW cycle of idx=NUM_DIGITS-1: idx wraps to 0, frame_done=1 next cycle,
//     active<=pending if pending full (pending cleared), lz latch<=lz_suppress.
//   Frame length = NUM_DIGITS*(BLANK_TICKS+DIGIT_TICKS) cycles exactly; no gaps, no stalls.
//   Handshake: value_ready = !pending_full. Transfer loads pending; a second value waits
//     (ready=0) until boundary. Ready rises the cycle after the boundary. value_in is ignored
//     when ready=0; valid may drop without transfer.
//   dec_nibble = active[4*idx +: 4] every cycle (also during BLANK); decoder is combinational.
//   Output registers load each cycle from the current state (1-cycle latency):
//     BLANK -> seg_out off, an_out all inactive.
//     SHOW  -> an_out bit idx active; seg_out = dec_seg, or off if digit suppressed.
//   Suppression: with lz latch=1, digit i>0 is suppressed iff nibbles NUM_DIGITS-1..i are all 0.
//     Digit 0 is never suppressed (value 0 shows "0"). Its an_out bit is still asserted.
//   Polarity: "off" and "active" follow SEG_ACTIVE_LOW/AN_ACTIVE_LOW. Internal logic is active-high.
//   Width: tick counter sized $clog2(max(DIGIT_TICKS,BLANK_TICKS)). idx sized $clog2(NUM_DIGITS).
//   Invariant: never two an_out bits active; an_out never changes without >=BLANK_TICKS dark cycles.
// TESTING  (defaults, AN_ACTIVE_LOW=1, SEG_ACTIVE_LOW=0 unless stated)
//   Reset, no value: cycles 1..16 an_out=4'hF,seg=0; cycles 17..1016 an_out=4'hE, seg_out=7'h3F.
//   Load 16'h12A7 mid-frame: display unchanged until frame_done; next frame digits 0..3 show
//     7'h07,7'h77,7'h5B,7'h06.
//   Back-to-back: valid held with 16'h1111 then 16'h2222: first accepted, ready=0 until boundary.
//     Second accepted the cycle after frame_done; frames show 1111 then 2222, none lost.
//   lz_suppress=1, value 16'h0050: digits 3,2 seg_out=0 with an_out asserted; digits 1,0 show
//     7'h6D, 7'h3F. Value 16'h0000 shows only digit 0 = 7'h3F.
//   rst_n low in SHOW of digit 2: seg/an go off same cycle, ready=1. After release, scan restarts
//     at digit 0 with value 0.
//   Assertion across random stimulus: onehot0(~an_out), frame period = 4064 cycles,
//     frame_done exactly one per frame.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed scan controller for a NUM_DIGITS hex display that
//   shares one external seven-segment decoder; each digit slot is BLANK_TICKS dark cycles
//   followed by DIGIT_TICKS lit cycles. New values are taken by valid/ready into a one-entry
//   pending slot and become visible only at a frame boundary, so a frame never tears.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   value_in/_valid/_ready   packed hex value (nibble i -> digit i), valid/ready handshake
//   lz_suppress         blank leading zero digits (latched at frame boundary)
//   dec_nibble/dec_seg  nibble to the shared decoder / its active-high segments (a=bit0)
//   seg_out, an_out     registered segment and digit-enable drive (polarity by parameter)
//   frame_done          one-cycle pulse after each frame boundary
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_TICKS    = 1000,
  parameter int BLANK_TICKS    = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   value_in,
  input  logic                      value_valid,
  output logic                      value_ready,
  input  logic                      lz_suppress,
  output logic [3:0]                dec_nibble,
  input  logic [6:0]                dec_seg,
  output logic [6:0]                seg_out,
  output logic [NUM_DIGITS-1:0]     an_out,
  output logic                      frame_done
);

  localparam int MAXT = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);

  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
  localparam logic [TW-1:0] DIGIT_LAST = TW'(DIGIT_TICKS - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  // Electrical "off"/"inactive" levels; everything upstream of the output registers is active-high.
  localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t                  state, state_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [TW-1:0]           tick, tick_nxt;
  logic                    boundary;

  logic [4*NUM_DIGITS-1:0] active_val;
  logic [4*NUM_DIGITS-1:0] pending_val;
  logic                    pending_full;
  logic                    lz_latch;

  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   supp;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   an_hot;
  logic [6:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
    assign nib[g] = active_val[4*g +: 4];
  end

  // Decoder is fed even while dark so its output has settled by the first lit cycle.
  assign dec_nibble  = nib[idx];
  assign value_ready = !pending_full;

  // Digit i>0 is a leading zero when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    zero_run = 1'b1;
    supp     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (nib[i] == 4'h0);
      if (i > 0) supp[i] = lz_latch && zero_run;
    end
  end

  assign an_hot = NUM_DIGITS'(1) << idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BLANK;
      idx   <= '0;
      tick  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      tick  <= tick_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    tick_nxt  = tick + TW'(1);
    boundary  = 1'b0;
    seg_nxt   = SEG_OFF;
    an_nxt    = AN_OFF;
    case (state)
      ST_BLANK: begin
        if (tick == BLANK_LAST) begin
          state_nxt = ST_SHOW;
          tick_nxt  = '0;
        end
      end
      ST_SHOW: begin
        an_nxt  = AN_ACTIVE_LOW ? ~an_hot : an_hot;
        seg_nxt = supp[idx] ? SEG_OFF : (SEG_ACTIVE_LOW ? ~dec_seg : dec_seg);
        if (tick == DIGIT_LAST) begin
          state_nxt = ST_BLANK;
          tick_nxt  = '0;
          if (idx == IDX_LAST) begin
            idx_nxt  = '0;
            boundary = 1'b1;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_BLANK;
        idx_nxt   = '0;
        tick_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out    <= SEG_OFF;
      an_out     <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      seg_out    <= seg_nxt;
      an_out     <= an_nxt;
      frame_done <= boundary;
    end
  end

  // A pending value is promoted only at the boundary; ready is low while it waits, so a
  // transfer can only coincide with a boundary when the slot was already empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_val   <= '0;
      pending_val  <= '0;
      pending_full <= 1'b0;
      lz_latch     <= 1'b0;
    end else begin
      if (boundary) lz_latch <= lz_suppress;
      if (boundary && pending_full) begin
        active_val   <= pending_val;
        pending_full <= 1'b0;
      end else if (value_valid && !pending_full) begin
        pending_val  <= value_in;
        pending_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
module tb_seven_seg_scan_ctrl;
  localparam int ND    = 4;
  localparam int DT    = 1000;
  localparam int BT    = 16;
  localparam int SLOT  = DT + BT;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value_in;
  logic        value_valid;
  logic        value_ready;
  logic        lz_suppress;
  logic [3:0]  dec_nibble;
  logic [6:0]  dec_seg;
  logic [6:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .value_in(value_in), .value_valid(value_valid), .value_ready(value_ready),
    .lz_suppress(lz_suppress),
    .dec_nibble(dec_nibble), .dec_seg(dec_seg),
    .seg_out(seg_out), .an_out(an_out), .frame_done(frame_done)
  );

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
    endcase
  endfunction

  assign dec_seg = hex7(dec_nibble);

  // Reference model: time since reset release, the value on display, the queued value.
  int          t;
  logic [15:0] m_act;
  logic [15:0] m_pend;
  bit          m_full;
  bit          m_lz;
  int          last_fd;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0; m_act = '0; m_pend = '0; m_full = 0; m_lz = 0; last_fd = -1;
  endtask

  // One clock: expectations come from where the model says the scan is (slot/digit/phase).
  task automatic cyc();
    int          w, d;
    bit          bnd, xfer, sup;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic [3:0]  ohot;
    w    = t % SLOT;
    d    = (t / SLOT) % ND;
    bnd  = (t % FRAME) == FRAME - 1;
    xfer = value_valid && !m_full;
    if (w < BT) begin
      exp_an  = 4'hF;
      exp_seg = 7'h00;
    end else begin
      exp_an  = ~(4'b0001 << d);
      sup     = m_lz && (d > 0) && ((m_act >> (4 * d)) == 16'h0);
      exp_seg = sup ? 7'h00 : hex7(4'((m_act >> (4 * d)) & 16'hF));
    end
    @(posedge clk);
    #1;
    chk("an_out", 32'(an_out), 32'(exp_an));
    chk("seg_out", 32'(seg_out), 32'(exp_seg));
    chk("frame_done", 32'(frame_done), 32'(bnd));
    ohot = ~an_out;
    chk("an_onehot0", 32'($onehot0(ohot)), 32'd1);
    if (bnd) begin
      m_lz = lz_suppress;
      if (m_full) begin
        m_act  = m_pend;
        m_full = 0;
        xfer   = 0;
      end
    end
    if (xfer) begin
      m_pend = value_in;
      m_full = 1;
    end
    chk("value_ready", 32'(value_ready), 32'(!m_full));
    if (frame_done) begin
      if (last_fd >= 0) chk("frame_period", 32'(t - last_fd), 32'(FRAME));
      last_fd = t;
    end
    t++;
  endtask

  task automatic run_to(input int pos);
    int n;
    n = 0;
    while ((t % FRAME) != pos && n <= FRAME) begin
      cyc();
      n++;
    end
    chk("run_to_reached", 32'(t % FRAME), 32'(pos));
  endtask

  task automatic offer(input logic [15:0] v);
    value_in    = v;
    value_valid = 1'b1;
    cyc();
    value_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; value_in = '0; value_valid = 1'b0; lz_suppress = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", 32'(an_out), 32'hF);
    chk("rst_seg", 32'(seg_out), 32'h0);
    chk("rst_ready", 32'(value_ready), 32'h1);
    chk("rst_fd", 32'(frame_done), 32'h0);
    rst_n = 1'b1;

    // Reset, no value: 16 dark cycles then digit 0 shows "0".
    repeat (16) cyc();
    chk("cyc16_an", 32'(an_out), 32'hF);
    cyc();
    chk("cyc17_an", 32'(an_out), 32'hE);
    chk("cyc17_seg", 32'(seg_out), 32'h3F);

    // Mid-frame load of 12A7: unchanged until the boundary.
    run_to(2000);
    offer(16'h12A7);
    run_to(2 * SLOT + BT + 5);
    chk("pre_bnd_seg", 32'(seg_out), 32'h3F);
    run_to(0);
    run_to(BT + 5);            chk("d0_12A7", 32'(seg_out), 32'h07);
    run_to(SLOT + BT + 5);     chk("d1_12A7", 32'(seg_out), 32'h77);
    run_to(2 * SLOT + BT + 5); chk("d2_12A7", 32'(seg_out), 32'h5B);
    run_to(3 * SLOT + BT + 5); chk("d3_12A7", 32'(seg_out), 32'h06);
    run_to(0);

    // Back-to-back: 1111 taken at once, 2222 waits for the boundary.
    value_valid = 1'b1;
    value_in    = 16'h1111;
    cyc();
    value_in = 16'h2222;
    n = 0;
    while (!value_ready && n <= FRAME) begin
      cyc();
      n++;
    end
    chk("b2b_accept_pos", 32'(t % FRAME), 32'h0);
    cyc();
    value_valid = 1'b0;
    run_to(SLOT + BT + 5);     chk("b2b_1111", 32'(seg_out), 32'h06);
    run_to(0);
    run_to(SLOT + BT + 5);     chk("b2b_2222", 32'(seg_out), 32'h5B);

    // Leading-zero suppression.
    lz_suppress = 1'b1;
    offer(16'h0050);
    run_to(0);
    run_to(BT + 5);            chk("lz_d0", 32'(seg_out), 32'h3F);
    run_to(SLOT + BT + 5);     chk("lz_d1", 32'(seg_out), 32'h6D);
    run_to(2 * SLOT + BT + 5); chk("lz_d2_seg", 32'(seg_out), 32'h0); chk("lz_d2_an", 32'(an_out), 32'hB);
    run_to(3 * SLOT + BT + 5); chk("lz_d3_seg", 32'(seg_out), 32'h0); chk("lz_d3_an", 32'(an_out), 32'h7);
    offer(16'h0000);
    run_to(0);
    run_to(BT + 5);            chk("lz0_d0", 32'(seg_out), 32'h3F);
    run_to(SLOT + BT + 5);     chk("lz0_d1", 32'(seg_out), 32'h0);

    // Reset in SHOW of digit 2 with a value pending.
    lz_suppress = 1'b0;
    offer(16'hBEEF);
    run_to(0);
    offer(16'h4321);
    run_to(2 * SLOT + BT + 100);
    chk("pre_rst_seg", 32'(seg_out), 32'(hex7(4'hE)));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_an", 32'(an_out), 32'hF);
    chk("mid_rst_seg", 32'(seg_out), 32'h0);
    chk("mid_rst_ready", 32'(value_ready), 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    run_to(BT + 5);
    chk("post_rst_an", 32'(an_out), 32'hE);
    chk("post_rst_seg", 32'(seg_out), 32'h3F);
    run_to(0);

    // Random traffic against the model.
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      value_valid = 1'($urandom_range(0, 1));
      lz_suppress = 1'($urandom_range(0, 1));
      value_in    = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
